// File: rtl/sh_rx_pkg.sv
// rtl/sh_rx_pkg.sv - shared types and constants for the Steelhorse receive word packer
package sh_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_DISCARD,
        ST_FLUSH,
        ST_REPORT
    } sh_rx_state_e;

    localparam int WORD_W        = 32;
    localparam int LANE_W        = 2;
    localparam int REPORT_CYCLES = 2;
    localparam int DROP_W        = 8;

    // Saturating add used by the drop counter; several drop events can land in one cycle.
    function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] cnt,
                                                       input logic [1:0]        inc);
        logic [DROP_W:0] sum;
        sum = {1'b0, cnt} + {{(DROP_W-1){1'b0}}, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/sh_rx_lane_packer.sv
// rtl/sh_rx_lane_packer.sv - octet lane register that assembles little-endian 32-bit words
module sh_rx_lane_packer
    import sh_rx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        octet_i,
    input  logic              push_i,
    input  logic              clear_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_done_o,
    output logic              pending_o
);

    logic [WORD_W-1:0] lane_q, lane_d;
    logic [LANE_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] packed_w;
    logic [LANE_W:0]   fill;

    // Merge this cycle's octet into the lanes; word_o shows it immediately so a
    // completing or flushing word can be latched by the top on the same edge.
    always_comb begin
        packed_w = lane_q;
        if (push_i) begin
            packed_w[{idx_q, 3'b000} +: 8] = octet_i;
        end
        fill = {1'b0, idx_q} + {{LANE_W{1'b0}}, push_i};
        word_o = '0;
        for (int l = 0; l < 4; l++) begin
            if (3'(l) < fill) begin
                word_o[l*8 +: 8] = packed_w[l*8 +: 8];
            end
        end
        word_done_o = push_i && (idx_q == 2'd3);
        pending_o   = (fill != '0) && !word_done_o;
        if (clear_i || word_done_o) begin
            lane_d = '0;
            idx_d  = '0;
        end else if (push_i) begin
            lane_d = packed_w;
            idx_d  = idx_q + 2'd1;
        end else begin
            lane_d = lane_q;
            idx_d  = idx_q;
        end
    end

    // Lane register and lane index; a word completion or clear restarts at lane 0.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            lane_q <= '0;
            idx_q  <= '0;
        end else begin
            lane_q <= lane_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/sh_rx_word_packer.sv
// rtl/sh_rx_word_packer.sv - Steelhorse receive octet-to-word packer with frame reporting
module sh_rx_word_packer
    import sh_rx_pkg::*;
#(
    parameter int MAX_OCTETS = 1536,
    parameter int MIN_OCTETS = 64,
    parameter int LEN_W      = 11
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        RX_OCTET,
    input  logic              RX_OCTET_VLD,
    input  logic              RX_EOF,
    input  logic              RX_CRC_OK,
    output logic [WORD_W-1:0] DATA_OUT,
    output logic              WRITE_OUT,
    output logic              NEW_PCKT,
    output logic              NEW_PCKT_VALID,
    output logic [LEN_W-1:0]  FRAME_LEN,
    output logic [DROP_W-1:0] DROP_CNT
);

    sh_rx_state_e      state_q;
    logic [LEN_W-1:0]  len_q;
    logic              crc_q;
    logic [1:0]        rpt_q;
    logic [WORD_W-1:0] data_q;
    logic              write_q;
    logic              npk_q;
    logic              valid_q;
    logic [LEN_W-1:0]  flen_q;
    logic [DROP_W-1:0] drop_q;

    logic              in_frame;
    logic              push;
    logic              clear;
    logic [LEN_W-1:0]  len_nxt;
    logic              hit_max;
    logic [WORD_W-1:0] word;
    logic              word_done;
    logic              pending;
    logic              flush_enter;
    logic              report_enter;
    logic              rpt_crc;
    logic [LEN_W-1:0]  rpt_len;
    logic              rpt_valid;
    logic [1:0]        drop_inc;

    // Octets are packed only while a frame is open; an EOF or truncation empties the lanes.
    always_comb begin
        in_frame = (state_q == ST_IDLE) || (state_q == ST_RECV);
        push     = in_frame && RX_OCTET_VLD;
        len_nxt  = ((state_q == ST_IDLE) ? '0 : len_q) + LEN_W'(push);
        hit_max  = len_nxt >= LEN_W'(MAX_OCTETS);
        clear    = in_frame && (RX_EOF || hit_max);
    end

    sh_rx_lane_packer u_lanes (
        .CLK         (CLK),
        .RST         (RST),
        .octet_i     (RX_OCTET),
        .push_i      (push),
        .clear_i     (clear),
        .word_o      (word),
        .word_done_o (word_done),
        .pending_o   (pending)
    );

    // Frame-end decisions, verdict inputs per entry path, and drop events of this cycle.
    always_comb begin
        flush_enter  = in_frame && RX_EOF && pending;
        report_enter = (in_frame && RX_EOF && !pending && ((state_q == ST_RECV) || push))
                     || (state_q == ST_FLUSH)
                     || ((state_q == ST_DISCARD) && RX_EOF);
        rpt_crc = RX_CRC_OK;
        rpt_len = len_nxt;
        if (state_q == ST_FLUSH) begin
            rpt_crc = crc_q;
            rpt_len = len_q;
        end else if (state_q == ST_DISCARD) begin
            rpt_crc = 1'b0;
            rpt_len = LEN_W'(MAX_OCTETS);
        end
        rpt_valid = rpt_crc && (rpt_len >= LEN_W'(MIN_OCTETS)) && (rpt_len < LEN_W'(MAX_OCTETS));
        drop_inc = 2'd0;
        if ((state_q == ST_IDLE) && RX_EOF && !RX_OCTET_VLD) begin
            drop_inc = drop_inc + 2'd1;
        end
        if (((state_q == ST_FLUSH) || (state_q == ST_REPORT)) && RX_OCTET_VLD) begin
            drop_inc = drop_inc + 2'd1;
        end
        if (report_enter && !rpt_valid) begin
            drop_inc = drop_inc + 2'd1;
        end
    end

    // Frame FSM with registered word strobe, report event and counters.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            crc_q   <= 1'b0;
            rpt_q   <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            npk_q   <= 1'b0;
            valid_q <= 1'b0;
            flen_q  <= '0;
            drop_q  <= '0;
        end else begin
            write_q <= 1'b0;
            drop_q  <= drop_sat_add(drop_q, drop_inc);
            if (word_done || flush_enter) begin
                data_q  <= word;
                write_q <= 1'b1;
            end
            if (report_enter) begin
                npk_q   <= 1'b1;
                valid_q <= rpt_valid;
                flen_q  <= rpt_len;
                rpt_q   <= '0;
            end
            case (state_q)
                ST_IDLE, ST_RECV: begin
                    if (push) begin
                        len_q <= len_nxt;
                    end
                    if (RX_EOF) begin
                        crc_q <= RX_CRC_OK;
                    end
                    if (flush_enter) begin
                        state_q <= ST_FLUSH;
                    end else if (report_enter) begin
                        state_q <= ST_REPORT;
                    end else if (push && hit_max) begin
                        state_q <= ST_DISCARD;
                    end else if (push) begin
                        state_q <= ST_RECV;
                    end
                end
                ST_DISCARD: begin
                    if (RX_EOF) begin
                        state_q <= ST_REPORT;
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (rpt_q == 2'(REPORT_CYCLES - 1)) begin
                        npk_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        rpt_q <= rpt_q + 2'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign DATA_OUT       = data_q;
    assign WRITE_OUT      = write_q;
    assign NEW_PCKT       = npk_q;
    assign NEW_PCKT_VALID = valid_q;
    assign FRAME_LEN      = flen_q;
    assign DROP_CNT       = drop_q;

endmodule

// File: tb/tb_sh_rx_word_packer.sv
// tb/tb_sh_rx_word_packer.sv - self-checking bench for sh_rx_word_packer
module tb_sh_rx_word_packer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [7:0]  RX_OCTET = 8'h00;
    logic        RX_OCTET_VLD = 1'b0;
    logic        RX_EOF = 1'b0;
    logic        RX_CRC_OK = 1'b0;
    logic [31:0] DATA_OUT;
    logic        WRITE_OUT;
    logic        NEW_PCKT;
    logic        NEW_PCKT_VALID;
    logic [10:0] FRAME_LEN;
    logic [7:0]  DROP_CNT;

    sh_rx_word_packer dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_OCTET       (RX_OCTET),
        .RX_OCTET_VLD   (RX_OCTET_VLD),
        .RX_EOF         (RX_EOF),
        .RX_CRC_OK      (RX_CRC_OK),
        .DATA_OUT       (DATA_OUT),
        .WRITE_OUT      (WRITE_OUT),
        .NEW_PCKT       (NEW_PCKT),
        .NEW_PCKT_VALID (NEW_PCKT_VALID),
        .FRAME_LEN      (FRAME_LEN),
        .DROP_CNT       (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          n;
        bit          eof_after;
        bit          crc;
        int          exp_writes;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        bit          exp_valid;
        int          exp_len;
        int          exp_drop;
    } vec_t;

    vec_t        vecs [6];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] wq [$];
    int          np_events = 0;
    int          np_run = 0;
    bit          np_valid = 1'b0;
    bit          np_prev = 1'b0;

    // Monitor: record every written word and the length/verdict of each NEW_PCKT run.
    always @(negedge CLK) begin
        if (WRITE_OUT) wq.push_back(DATA_OUT);
        if (NEW_PCKT) begin
            if (!np_prev) begin
                np_events = np_events + 1;
                np_run = 0;
            end
            np_run = np_run + 1;
            np_valid = NEW_PCKT_VALID;
        end
        np_prev = NEW_PCKT;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_frame(input int n, input bit eof_after, input bit crc);
        for (int i = 0; i < n; i++) begin
            step();
            RX_OCTET_VLD = 1'b1;
            RX_OCTET     = 8'(i);
            RX_EOF       = !eof_after && (i == n - 1);
            RX_CRC_OK    = crc;
        end
        step();
        RX_OCTET_VLD = 1'b0;
        RX_EOF       = eof_after;
        RX_CRC_OK    = crc;
        step();
        RX_EOF = 1'b0;
    endtask

    task automatic wait_report(input int ev0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (np_events > ev0 && !NEW_PCKT) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int          ev0;
        int          w0;
        int          nw;
        int          bad;
        int          lim;
        int          b;
        bit          ok;
        logic [31:0] expw;

        vecs[0] = '{64,   1'b1, 1'b1, 16,  32'h03020100, 32'h3F3E3D3C, 1'b1, 64,   0};
        vecs[1] = '{67,   1'b1, 1'b1, 17,  32'h03020100, 32'h00424140, 1'b1, 67,   0};
        vecs[2] = '{40,   1'b1, 1'b1, 10,  32'h03020100, 32'h27262524, 1'b0, 40,   1};
        vecs[3] = '{100,  1'b0, 1'b0, 25,  32'h03020100, 32'h63626160, 1'b0, 100,  2};
        vecs[4] = '{1600, 1'b1, 1'b1, 384, 32'h03020100, 32'hFFFEFDFC, 1'b0, 1536, 3};
        vecs[5] = '{65,   1'b0, 1'b1, 17,  32'h03020100, 32'h00000040, 1'b1, 65,   3};

        repeat (3) step();
        @(negedge CLK);
        check("reset_outputs", {DATA_OUT, WRITE_OUT, NEW_PCKT, NEW_PCKT_VALID, FRAME_LEN, DROP_CNT}, 64'h0);
        step();
        RST = 1'b1;
        repeat (2) step();

        for (int v = 0; v < 6; v++) begin
            ev0 = np_events;
            w0  = wq.size();
            run_frame(vecs[v].n, vecs[v].eof_after, vecs[v].crc);
            wait_report(ev0, ok);
            check($sformatf("v%0d_report_seen", v), ok, 1);
            nw = wq.size() - w0;
            check($sformatf("v%0d_writes", v), nw, vecs[v].exp_writes);
            if (nw > 0) begin
                check($sformatf("v%0d_first_word", v), wq[w0], vecs[v].exp_first);
                check($sformatf("v%0d_last_word", v), wq[wq.size() - 1], vecs[v].exp_last);
            end
            check($sformatf("v%0d_npkt_cycles", v), np_run, 2);
            check($sformatf("v%0d_valid", v), np_valid, vecs[v].exp_valid);
            check($sformatf("v%0d_len", v), FRAME_LEN, vecs[v].exp_len);
            check($sformatf("v%0d_drop", v), DROP_CNT, vecs[v].exp_drop);
            bad = 0;
            lim = (vecs[v].n < 1536) ? vecs[v].n : 1536;
            for (int k = 0; k < nw; k++) begin
                expw = 32'h0;
                for (int j = 0; j < 4; j++) begin
                    b = 4 * k + j;
                    if (b < lim) expw[j*8 +: 8] = 8'(b);
                end
                if (wq[w0 + k] !== expw) bad = bad + 1;
            end
            check($sformatf("v%0d_word_contents", v), bad, 0);
        end

        // Octet on lane 3 together with EOF: one write, no flush, report on the next cycle.
        for (int i = 0; i < 4; i++) begin
            step();
            RX_OCTET_VLD = 1'b1;
            RX_OCTET     = 8'(i);
            RX_EOF       = (i == 3);
            RX_CRC_OK    = 1'b1;
        end
        step();
        RX_OCTET_VLD = 1'b0;
        RX_EOF       = 1'b0;
        @(negedge CLK);
        check("eof_lane3_t1", {WRITE_OUT, NEW_PCKT, DATA_OUT}, {1'b1, 1'b1, 32'h03020100});
        step();
        @(negedge CLK);
        check("eof_lane3_t2", {WRITE_OUT, NEW_PCKT}, 2'b01);
        step();
        @(negedge CLK);
        check("eof_lane3_t3", {WRITE_OUT, NEW_PCKT}, 2'b00);
        check("eof_lane3_len_drop", {FRAME_LEN, DROP_CNT}, {11'd4, 8'd4});

        // EOF while idle: no report, one drop.
        repeat (2) step();
        ev0 = np_events;
        RX_EOF = 1'b1;
        step();
        RX_EOF = 1'b0;
        repeat (6) step();
        check("idle_eof_no_report", np_events, ev0);
        check("idle_eof_drop", DROP_CNT, 5);

        // Octet arriving during REPORT is discarded and counted.
        ev0 = np_events;
        w0  = wq.size();
        for (int i = 0; i < 8; i++) begin
            step();
            RX_OCTET_VLD = 1'b1;
            RX_OCTET     = 8'(i);
            RX_CRC_OK    = 1'b1;
        end
        step();
        RX_OCTET_VLD = 1'b0;
        RX_EOF       = 1'b1;
        step();
        RX_EOF       = 1'b0;
        RX_OCTET_VLD = 1'b1;
        RX_OCTET     = 8'hAA;
        step();
        RX_OCTET_VLD = 1'b0;
        repeat (6) step();
        check("report_octet_events", np_events - ev0, 1);
        check("report_octet_writes", wq.size() - w0, 2);
        check("report_octet_drop", DROP_CNT, 7);
        check("report_octet_len", FRAME_LEN, 8);

        // Reset mid-frame loses the partial frame; the next frame starts fresh.
        for (int i = 0; i < 10; i++) begin
            step();
            RX_OCTET_VLD = 1'b1;
            RX_OCTET     = 8'(i);
        end
        step();
        RX_OCTET_VLD = 1'b0;
        RST = 1'b0;
        step();
        @(negedge CLK);
        ev0 = np_events;
        w0  = wq.size();
        check("midreset_outputs", {DATA_OUT, WRITE_OUT, NEW_PCKT, NEW_PCKT_VALID, FRAME_LEN, DROP_CNT}, 64'h0);
        step();
        RST = 1'b1;
        repeat (5) step();
        check("midreset_quiet", {32'(wq.size() - w0), 32'(np_events - ev0)}, 64'h0);
        run_frame(64, 1'b1, 1'b1);
        wait_report(ev0, ok);
        check("post_reset_report_seen", ok, 1);
        check("post_reset_writes", wq.size() - w0, 16);
        check("post_reset_report", {np_valid, FRAME_LEN, DROP_CNT}, {1'b1, 11'd64, 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sh_rx_word_packer.md
# sh_rx_word_packer

Receive-side octet-to-word packer for Steelhorse, placed between the Steelhorse receiver octet stream and `sh_hf_adaptor`. It packs received octets into 32-bit little-endian words and emits one `WRITE_OUT` strobe per word. At frame end it flushes a zero-padded partial word, then raises `NEW_PCKT` with a validity verdict and the octet length. The adaptor forwards these words and events into the hyperfabric LSAB.

## Interface
Parameters:
- `MAX_OCTETS`, 1536: frames reaching this octet count are truncated and marked invalid.
- `MIN_OCTETS`, 64: frames shorter than this are marked invalid (runt).
- `LEN_W`, 11: width of `FRAME_LEN`; must satisfy 2^LEN_W > `MAX_OCTETS`.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset, synchronous, active-low.
- `RX_OCTET`  in  8  received octet.
- `RX_OCTET_VLD`  in  1  `RX_OCTET` is valid this cycle; at most one octet per cycle.
- `RX_EOF`  in  1  one-cycle frame-end pulse; may coincide with or follow the last octet.
- `RX_CRC_OK`  in  1  CRC verdict; sampled only when `RX_EOF` is high.
- `DATA_OUT`  out  32  packed word; feeds the adaptor `DATA_FROM_ETH`.
- `WRITE_OUT`  out  1  one-cycle strobe per word; feeds the adaptor `WRITE_IN`.
- `NEW_PCKT`  out  1  frame-end event; high for exactly 2 cycles.
- `NEW_PCKT_VALID`  out  1  frame verdict; stable while `NEW_PCKT` is high.
- `FRAME_LEN`  out  `LEN_W`  octet count of the last frame; held until the next report.
- `DROP_CNT`  out  8  saturating count of invalid or discarded events.

## Operation
- Reset values: all outputs 0; FSM in IDLE; lane index 0; packing register 0.
- FSM states:
  - **IDLE**: the first `RX_OCTET_VLD` is stored in lane 0; go to RECV.
  - **RECV**: pack octets; lane = octet index mod 4; octet 0 → bits 7:0.
    - When lane 3 is filled, latch the word into `DATA_OUT` and pulse `WRITE_OUT` next cycle.
    - On `RX_EOF`: go to FLUSH if the lane index ≠ 0, else go to REPORT.
    - If the octet count reaches `MAX_OCTETS`, go to DISCARD.
  - **DISCARD**: accept octets with no writes; `FRAME_LEN` saturates at `MAX_OCTETS`. On `RX_EOF` go to REPORT with verdict 0.
  - **FLUSH**: one cycle; latch the partial word with unused upper lanes zeroed, pulse `WRITE_OUT`, go to REPORT.
  - **REPORT**: two cycles with `NEW_PCKT` = 1, then IDLE.
    - `NEW_PCKT_VALID` = `RX_CRC_OK` (captured at EOF) && len ≥ `MIN_OCTETS` && !oversize.
    - `FRAME_LEN` is updated on REPORT entry.
- `DROP_CNT` increments by one, saturating at 255, for each of:
  - a report with verdict 0;
  - `RX_EOF` received in IDLE (no report is produced);
  - each octet arriving in FLUSH or REPORT (the octet is discarded).
- Octet and `RX_EOF` in the same cycle: the octet is packed first, then EOF is processed. If that octet fills lane 3, the word is written and the next state is REPORT.
- The Steelhorse CRC octets are packed as data; no stripping is done. Consumers use `FRAME_LEN`.

## Timing
- Word latency: `WRITE_OUT` is high in the cycle after the 4th octet of a word is accepted.
- `DATA_OUT` changes only in cycles where `WRITE_OUT` is high, and holds until the next strobe. Whenever the next `WRITE_OUT` strobe occurs at least 4 cycles later, this satisfies the adaptor's capture on its LSAB turn.
- Frame end, octet aligned: `RX_EOF` at cycle t → `NEW_PCKT` high at t+1 and t+2.
- Frame end, partial word: `RX_EOF` at cycle t → `WRITE_OUT` at t+1 → `NEW_PCKT` high at t+2 and t+3.
- `NEW_PCKT` always returns low for at least one cycle before the next event, so the adaptor's rising-edge detector sees every frame.
- Reset mid-frame: the partial word is lost, no strobe or report is issued, and the next octet starts a fresh frame.

## Structure
- Shared package `sh_rx_pkg`:
  - FSM state typedef (IDLE, RECV, DISCARD, FLUSH, REPORT);
  - lane index width (2);
  - `REPORT_CYCLES` = 2;
  - drop-counter width (8).
- One sub-module: `sh_rx_lane_packer`. It contains the lane register, lane index, zero-fill on flush, and word-complete flag. The FSM, length counter and counters stay in the top level.

## Test plan
- Data path, 64-octet frame with octets 0x00..0x3F, CRC ok:
  - 16 `WRITE_OUT` pulses; first word 0x03020100, last word 0x3F3E3D3C.
  - `NEW_PCKT` for 2 cycles with VALID = 1 and `FRAME_LEN` = 64; `DROP_CNT` = 0.
- Partial-word flush, 67-octet frame with EOF one cycle after the last octet:
  - 17th word = 0x00424140, which is the flush word.
  - `NEW_PCKT` follows the flush; `FRAME_LEN` = 67, VALID = 1.
- Runt and bad CRC:
  - 40-octet frame with CRC ok → VALID = 0, LEN = 40, `DROP_CNT` = 1.
  - Then a 100-octet frame with `RX_CRC_OK` = 0 → VALID = 0, `DROP_CNT` = 2.
- Oversize, 1600 octets:
  - exactly 384 `WRITE_OUT` pulses;
  - `FRAME_LEN` = 1536, VALID = 0.
- Edge cases:
  - Octet coinciding with `RX_EOF` on lane 3 → one write, no flush, `NEW_PCKT` next cycle.
  - `RX_EOF` while in IDLE → no report, `DROP_CNT` +1.
  - Octet arriving during REPORT is discarded and counted.
- Reset mid-frame:
  - Assert `RST` = 0 after 10 octets → no `WRITE_OUT`/`NEW_PCKT`, all outputs 0.
  - A following 64-octet frame reports LEN = 64.
